ufm_burst_fetcher: RTL

//  Downstream consumer of the UFM byte reader. Accepts a (start address, length) command and walks
//  the reader's byte address port one byte at a time. Collects each returned byte into a small FIFO
//  and presents the bytes as a valid/ready stream with an end-of-burst marker.

---
 rtl/ufm_burst_fetcher.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ufm_burst_fetcher.sv
// Burst fetcher: walks the UFM byte reader from a (start, length) command and
// streams the returned bytes out through a small FIFO with an end-of-burst marker.
module ufm_burst_fetcher #(
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [14:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             abort,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [14:0]      ur_byte_addr,
    output logic             ur_read_en,
    output logic             ur_stall,
    input  logic [7:0]       ur_data,
    input  logic             ur_valid
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [14:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [8:0]         fifo_mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic head_last;
    logic tmo_hit;

    assign push      = (state_q == S_REQ) && rd_en_q && ur_valid;
    assign pop       = (count_q != '0) && m_ready;
    assign head_last = fifo_mem_q[rd_ptr_q][8];
    assign tmo_hit   = (TIMEOUT != 0) && (state_q == S_REQ) && rd_en_q && !ur_valid
                       && (tmo_q == TMO_W'(TIMEOUT - 1));

    // NOTE: combinational blocks use blocking '=' with every output defaulted first,
    // so later assignments override earlier ones and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        done_d   = pop && head_last;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    err_d  = 1'b0;
                    tmo_d  = '0;
                    if (cmd_len == '0) done_d  = 1'b1;
                    else               state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (push) begin
                    addr_d  = addr_q + 15'd1;
                    rem_d   = rem_q - LEN_W'(1);
                    tmo_d   = '0;
                    state_d = S_GAP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else if (rd_en_q) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_GAP: begin
                // One dead cycle so a reader still answering the old address is ignored.
                state_d = (rem_q != '0) ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d  = S_IDLE;
            addr_d   = addr_q;
            rem_d    = rem_q;
            err_d    = err_q;
            tmo_d    = '0;
            done_d   = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Read request only while a FIFO slot is guaranteed for the returned byte.
    assign rd_en_d = (state_d == S_REQ) && (count_d != CNT_W'(FIFO_DEPTH));

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: FIFO storage is not reset; outputs that must read 0 from reset are
    // qualified by the reset occupancy count instead.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {(rem_q == LEN_W'(1)), ur_data};
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign m_valid      = (count_q != '0);
    assign m_data       = fifo_mem_q[rd_ptr_q][7:0];
    assign m_last       = m_valid && head_last;
    assign busy         = (state_q != S_IDLE) || m_valid;
    assign done         = done_q;
    assign err          = err_q;
    assign ur_byte_addr = addr_q;
    assign ur_read_en   = rd_en_q;
    assign ur_stall     = 1'b0;

endmodule
